// File: rtl/ysyx_23060236_rd_arbiter_if.sv
// Read-channel bundle between the IFU, the LSU, the arbiter and the xbar read port.
// The arbiter takes the slave view; the surrounding environment takes the master view.
interface ysyx_23060236_rd_arbiter_if;
  logic [31:0] ifu_araddr;
  logic [3:0]  ifu_arlen;
  logic [1:0]  ifu_arburst;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rlast;
  logic        ifu_rvalid;
  logic        ifu_rready;

  logic [31:0] lsu_araddr;
  logic [2:0]  lsu_arsize;
  logic        lsu_arvalid;
  logic        lsu_arready;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_rvalid;
  logic        lsu_rready;

  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        m_rvalid;
  logic        m_rready;

  modport slave (
    input  ifu_araddr, ifu_arlen, ifu_arburst, ifu_arvalid, ifu_rready,
    output ifu_arready, ifu_rdata, ifu_rresp, ifu_rlast, ifu_rvalid,
    input  lsu_araddr, lsu_arsize, lsu_arvalid, lsu_rready,
    output lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
    output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );

  modport master (
    output ifu_araddr, ifu_arlen, ifu_arburst, ifu_arvalid, ifu_rready,
    input  ifu_arready, ifu_rdata, ifu_rresp, ifu_rlast, ifu_rvalid,
    output lsu_araddr, lsu_arsize, lsu_arvalid, lsu_rready,
    input  lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
    input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );
endinterface

// File: rtl/ysyx_23060236_rd_arbiter.sv
// IFU/LSU read arbiter onto one downstream AXI read port: one transaction at a time,
// bounded LSU streak while IFU waits, and a sticky rlast/beat-count checker.
module ysyx_23060236_rd_arbiter #(
  parameter int unsigned LSU_STREAK = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  ysyx_23060236_rd_arbiter_if.slave     bus,
  output logic                          arb_err
);

  typedef enum logic [2:0] {IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(LSU_STREAK);

  state_t     state;
  logic       m_arvalid_q;
  logic [3:0] streak;
  logic [3:0] beat_cnt;
  logic [3:0] exp_last;

  logic lsu_win;
  logic beat_fire;
  logic beat_err;

  assign lsu_win   = bus.lsu_arvalid && !(bus.ifu_arvalid && (streak == STREAK_MAX));
  assign beat_fire = bus.m_rvalid && bus.m_rready;
  // A single LSU beat must also be the last one; the count test covers that, the
  // explicit term keeps the rule visible.
  assign beat_err  = (bus.m_rlast && (beat_cnt != exp_last)) ||
                     (!bus.m_rlast && (beat_cnt == exp_last)) ||
                     ((state == LSU_R) && !bus.m_rlast);

  always_comb begin
    bus.m_arvalid   = m_arvalid_q;
    bus.m_araddr    = '0;
    bus.m_arlen     = '0;
    bus.m_arsize    = '0;
    bus.m_arburst   = '0;
    bus.m_rready    = 1'b0;
    bus.ifu_arready = 1'b0;
    bus.lsu_arready = 1'b0;
    bus.ifu_rvalid  = 1'b0;
    bus.lsu_rvalid  = 1'b0;
    bus.ifu_rdata   = bus.m_rdata;
    bus.ifu_rresp   = bus.m_rresp;
    bus.ifu_rlast   = bus.m_rlast;
    bus.lsu_rdata   = bus.m_rdata;
    bus.lsu_rresp   = bus.m_rresp;
    case (state)
      IFU_AR: begin
        bus.m_araddr    = bus.ifu_araddr;
        bus.m_arlen     = {4'b0, bus.ifu_arlen};
        bus.m_arsize    = 3'b010;
        bus.m_arburst   = bus.ifu_arburst;
        bus.ifu_arready = bus.m_arready;
      end
      LSU_AR: begin
        bus.m_araddr    = bus.lsu_araddr;
        bus.m_arlen     = '0;
        bus.m_arsize    = bus.lsu_arsize;
        bus.m_arburst   = 2'b01;
        bus.lsu_arready = bus.m_arready;
      end
      IFU_R: begin
        bus.m_rready   = bus.ifu_rready;
        bus.ifu_rvalid = bus.m_rvalid;
      end
      LSU_R: begin
        bus.m_rready   = bus.lsu_rready;
        bus.lsu_rvalid = bus.m_rvalid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      m_arvalid_q <= 1'b0;
      streak      <= '0;
      beat_cnt    <= '0;
      exp_last    <= '0;
      arb_err     <= 1'b0;
    end else begin
      if (beat_fire) begin
        beat_cnt <= beat_cnt + 4'd1;
        if (beat_err) arb_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (lsu_win) begin
            state       <= LSU_AR;
            m_arvalid_q <= 1'b1;
            if (!bus.ifu_arvalid)        streak <= '0;
            else if (streak < STREAK_MAX) streak <= streak + 4'd1;
          end else if (bus.ifu_arvalid) begin
            state       <= IFU_AR;
            m_arvalid_q <= 1'b1;
            streak      <= '0;
          end
        end
        IFU_AR: begin
          if (bus.m_arready) begin
            state       <= IFU_R;
            m_arvalid_q <= 1'b0;
            exp_last    <= bus.ifu_arlen;
            beat_cnt    <= '0;
          end
        end
        LSU_AR: begin
          if (bus.m_arready) begin
            state       <= LSU_R;
            m_arvalid_q <= 1'b0;
            exp_last    <= '0;
            beat_cnt    <= '0;
          end
        end
        IFU_R: if (beat_fire && bus.m_rlast) state <= IDLE;
        LSU_R: if (beat_fire) state <= IDLE;
        default: begin
          state       <= IDLE;
          m_arvalid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_rd_arbiter.sv
// Scoreboard bench for the IFU/LSU read arbiter: request BFMs, a downstream slave model,
// and a monitor that checks every AR and R handshake against queued expectations.
module tb_ysyx_23060236_rd_arbiter;
  localparam int unsigned S = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic arb_err;

  ysyx_23060236_rd_arbiter_if bus();

  ysyx_23060236_rd_arbiter #(.LSU_STREAK(S)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .arb_err (arb_err)
  );

  always #5 clock = ~clock;

  typedef struct { bit is_ifu; logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; } ar_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; bit last; } beat_t;
  typedef struct { logic [31:0] addr; logic [3:0] len; logic [1:0] burst; } ireq_t;
  typedef struct { logic [31:0] addr; logic [2:0] size; } lreq_t;

  ireq_t ifu_q[$];
  lreq_t lsu_q[$];
  ireq_t stage_i[$];
  lreq_t stage_l[$];
  ar_t   exp_ar[$];
  beat_t exp_beat[$];
  logic [31:0] forced_data[$];

  int checks = 0;
  int errors = 0;
  int unsigned model_run = 0;
  int unsigned ar_count = 0;
  int unsigned abort_after = 0;
  int corrupt = 0;
  bit busy = 0;
  bit cur_ifu = 0;
  bit end_pending = 0;
  bit slave_aborted = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  function automatic ar_t ifu_ar(input ireq_t r);
    ar_t a;
    a.is_ifu = 1'b1; a.addr = r.addr; a.len = {4'b0, r.len}; a.size = 3'b010; a.burst = r.burst;
    return a;
  endfunction

  function automatic ar_t lsu_ar(input lreq_t r);
    ar_t a;
    a.is_ifu = 1'b0; a.addr = r.addr; a.len = 8'd0; a.size = r.size; a.burst = 2'b01;
    return a;
  endfunction

  // Grant order for staged requests issued together: LSU preferred, but after S LSU
  // grants with IFU waiting the IFU gets the next one.
  task automatic plan();
    int unsigned i, l;
    bit iw, lw;
    i = 0; l = 0;
    while (i < stage_i.size() || l < stage_l.size()) begin
      iw = (i < stage_i.size());
      lw = (l < stage_l.size());
      if (lw && !(iw && model_run == S)) begin
        exp_ar.push_back(lsu_ar(stage_l[l]));
        l++;
        model_run = iw ? ((model_run < S) ? model_run + 1 : S) : 0;
      end else begin
        exp_ar.push_back(ifu_ar(stage_i[i]));
        i++;
        model_run = 0;
      end
    end
    foreach (stage_i[k]) ifu_q.push_back(stage_i[k]);
    foreach (stage_l[k]) lsu_q.push_back(stage_l[k]);
    stage_i.delete();
    stage_l.delete();
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while ((exp_ar.size() != 0 || busy || ifu_q.size() != 0 || lsu_q.size() != 0) && n < 4000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 4000) begin
      checks++; errors++;
      $display("FAIL drain_%s actual=pending%0d required=pending0", name, exp_ar.size());
      finish_run();
    end
    @(negedge clock);
  endtask

  task automatic reset_pulse();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    model_run = 0;
    @(negedge clock);
  endtask

  task automatic push_ifu(input logic [3:0] len);
    ireq_t r;
    r.addr = $urandom; r.len = len; r.burst = 2'($urandom_range(3));
    stage_i.push_back(r);
  endtask

  task automatic push_lsu();
    lreq_t r;
    r.addr = $urandom; r.size = 3'($urandom_range(2));
    stage_l.push_back(r);
  endtask

  initial begin : ifu_bfm
    ireq_t r;
    bit fired;
    fired = 1'b0;
    bus.ifu_arvalid = 1'b0; bus.ifu_araddr = '0; bus.ifu_arlen = '0; bus.ifu_arburst = '0;
    bus.ifu_rready = 1'b0;
    forever begin
      @(posedge clock); #1;
      bus.ifu_rready = ($urandom_range(3) != 0);
      if (!bus.ifu_arvalid || fired) begin
        if (ifu_q.size() != 0) begin
          r = ifu_q.pop_front();
          bus.ifu_araddr = r.addr; bus.ifu_arlen = r.len; bus.ifu_arburst = r.burst;
          bus.ifu_arvalid = 1'b1;
        end else bus.ifu_arvalid = 1'b0;
      end
      @(negedge clock);
      fired = bus.ifu_arvalid && bus.ifu_arready;
    end
  end

  initial begin : lsu_bfm
    lreq_t r;
    bit fired;
    fired = 1'b0;
    bus.lsu_arvalid = 1'b0; bus.lsu_araddr = '0; bus.lsu_arsize = '0; bus.lsu_rready = 1'b0;
    forever begin
      @(posedge clock); #1;
      bus.lsu_rready = ($urandom_range(3) != 0);
      if (!bus.lsu_arvalid || fired) begin
        if (lsu_q.size() != 0) begin
          r = lsu_q.pop_front();
          bus.lsu_araddr = r.addr; bus.lsu_arsize = r.size;
          bus.lsu_arvalid = 1'b1;
        end else bus.lsu_arvalid = 1'b0;
      end
      @(negedge clock);
      fired = bus.lsu_arvalid && bus.lsu_arready;
    end
  end

  initial begin : slave
    int unsigned len, gap, n;
    bit stop, got;
    beat_t b;
    bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0; bus.m_rresp = '0; bus.m_rlast = 1'b0;
    forever begin
      @(posedge clock); #1;
      bus.m_arready = ($urandom_range(2) != 0);
      @(negedge clock);
      if (bus.m_arvalid && bus.m_arready && !reset) begin
        len = bus.m_arlen;
        @(posedge clock); #1;
        bus.m_arready = 1'b0;
        for (int unsigned i = 0; i <= len; i++) begin
          gap = $urandom_range(2);
          repeat (gap) begin @(posedge clock); #1; end
          if (forced_data.size() != 0) b.data = forced_data.pop_front();
          else b.data = $urandom;
          b.resp = 2'($urandom_range(3));
          stop   = (corrupt == 1) && (i == 2);
          b.last = ((i == len) && (corrupt != 2)) || stop;
          bus.m_rdata = b.data; bus.m_rresp = b.resp; bus.m_rlast = b.last;
          exp_beat.push_back(b);
          bus.m_rvalid = 1'b1;
          got = 1'b0;
          for (n = 0; n < 500 && !got; n++) begin @(negedge clock); got = bus.m_rready; end
          if (!got) begin
            checks++; errors++;
            $display("FAIL beat_accept_timeout actual=m_rready0 required=m_rready1 at %0t", $time);
          end
          @(posedge clock); #1;
          bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
          if (stop || (abort_after != 0 && i + 1 == abort_after)) begin
            slave_aborted = 1'b1;
            break;
          end
        end
      end
    end
  end

  initial begin : monitor
    ar_t   e;
    beat_t b;
    logic  g_rv, o_rv, g_rr, g_ar, o_ar;
    forever begin
      @(negedge clock);
      if (reset) begin
        busy = 1'b0; end_pending = 1'b0;
        exp_beat.delete();
      end else begin
        if (end_pending) begin
          check("idle_gap_after_last_beat", bus.m_arvalid, 1'b0);
          end_pending = 1'b0;
        end
        if (busy) begin
          check("ar_blocked_while_busy", {bus.m_arvalid, bus.ifu_arready, bus.lsu_arready}, 3'b000);
          if (bus.m_rvalid) begin
            g_rv = cur_ifu ? bus.ifu_rvalid : bus.lsu_rvalid;
            o_rv = cur_ifu ? bus.lsu_rvalid : bus.ifu_rvalid;
            g_rr = cur_ifu ? bus.ifu_rready : bus.lsu_rready;
            check("rvalid_route", {g_rv, o_rv}, 2'b10);
            check("rready_route", bus.m_rready, g_rr);
            if (bus.m_rready) begin
              if (exp_beat.size() == 0) check("beat_unexpected", 1'b1, 1'b0);
              else begin
                b = exp_beat.pop_front();
                check("rdata", cur_ifu ? bus.ifu_rdata : bus.lsu_rdata, b.data);
                check("rresp", cur_ifu ? bus.ifu_rresp : bus.lsu_rresp, b.resp);
                if (cur_ifu) check("ifu_rlast", bus.ifu_rlast, b.last);
                if (!cur_ifu || b.last) begin
                  busy = 1'b0;
                  end_pending = 1'b1;
                end
              end
            end
          end
        end else if (bus.m_arvalid) begin
          if (exp_ar.size() == 0) check("ar_unexpected", bus.m_arvalid, 1'b0);
          else begin
            e = exp_ar[0];
            g_ar = e.is_ifu ? bus.ifu_arready : bus.lsu_arready;
            o_ar = e.is_ifu ? bus.lsu_arready : bus.ifu_arready;
            check("arready_route", {g_ar, o_ar}, {bus.m_arready, 1'b0});
            if (bus.m_arready) begin
              void'(exp_ar.pop_front());
              check("ar_addr", bus.m_araddr, e.addr);
              check("ar_len", bus.m_arlen, e.len);
              check("ar_size", bus.m_arsize, e.size);
              check("ar_burst", bus.m_arburst, e.burst);
              busy = 1'b1;
              cur_ifu = e.is_ifu;
              ar_count++;
            end
          end
        end else begin
          check("idle_quiet", {bus.ifu_arready, bus.lsu_arready, bus.ifu_rvalid, bus.lsu_rvalid, bus.m_rready}, 5'b0);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    checks++; errors++;
    $display("FAIL watchdog actual=running required=finished");
    finish_run();
  end

  initial begin : main
    int unsigned n, a0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_outputs", {bus.m_arvalid, bus.m_rready, bus.ifu_arready, bus.lsu_arready,
                            bus.ifu_rvalid, bus.lsu_rvalid, arb_err}, 7'b0);

    // LSU-only load with a known data word; one-cycle grant latency from the request
    forced_data.push_back(32'hDEAD_BEEF);
    stage_l.push_back('{addr: 32'h8000_0100, size: 3'd2});
    plan();
    for (n = 0; n < 10 && !bus.lsu_arvalid; n++) @(negedge clock);
    check("ar_no_comb_path", bus.m_arvalid, 1'b0);
    @(negedge clock);
    check("grant_latency", bus.m_arvalid, 1'b1);
    drain("lsu_only");

    // IFU-only 4-beat burst
    stage_i.push_back('{addr: 32'h3000_0040, len: 4'd3, burst: 2'b01});
    plan();
    drain("ifu_only");
    check("err_clean_burst", arb_err, 1'b0);

    // contention: both queues loaded together, LSU streak bounded by S
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < int'($urandom_range(12, 6)); k++) push_lsu();
      for (int k = 0; k < int'($urandom_range(3, 1)); k++) push_ifu(4'($urandom_range(7)));
      plan();
      drain("contention");
    end
    check("err_clean_contention", arb_err, 1'b0);

    // LSU arrives while an IFU burst is in its data phase
    push_ifu(4'd3);
    plan();
    a0 = ar_count;
    for (n = 0; n < 200 && ar_count == a0; n++) @(negedge clock);
    push_lsu();
    plan();
    drain("lsu_during_burst");
    check("err_clean_late_lsu", arb_err, 1'b0);

    // early rlast on an IFU burst
    corrupt = 1;
    push_ifu(4'd3);
    plan();
    drain("early_rlast");
    corrupt = 0;
    check("err_early_rlast", arb_err, 1'b1);
    push_lsu();
    plan();
    drain("after_early_rlast");
    check("err_sticky", arb_err, 1'b1);
    reset_pulse();
    check("err_cleared_by_reset", arb_err, 1'b0);

    // LSU beat without rlast
    corrupt = 2;
    push_lsu();
    plan();
    drain("lsu_no_rlast");
    corrupt = 0;
    check("err_lsu_no_rlast", arb_err, 1'b1);

    // reset in the middle of an 8-beat IFU burst, then a normal load
    abort_after = 2;
    slave_aborted = 1'b0;
    push_ifu(4'd7);
    plan();
    for (n = 0; n < 1000 && !slave_aborted; n++) @(negedge clock);
    check("abort_reached", slave_aborted, 1'b1);
    reset_pulse();
    abort_after = 0;
    check("mid_burst_reset_outputs", {bus.m_arvalid, bus.m_rready, bus.ifu_arready, bus.lsu_arready,
                                      bus.ifu_rvalid, bus.lsu_rvalid, arb_err}, 7'b0);
    push_lsu();
    plan();
    drain("post_reset_load");
    check("err_clean_post_reset", arb_err, 1'b0);

    finish_run();
  end

endmodule
